// File: rtl/mul_pkg.sv
// Shared definitions for the radix-4 Booth / Wallace multiplier: digit encodings
// and elaboration-time helpers that size the reduction tree and place pipeline cuts.
package mul_pkg;

  typedef enum logic [2:0] {
    BOOTH_ZERO = 3'd0,
    BOOTH_P1   = 3'd1,
    BOOTH_P2   = 3'd2,
    BOOTH_M1   = 3'd3,
    BOOTH_M2   = 3'd4
  } booth_digit_e;

  function automatic booth_digit_e booth_encode(input logic [2:0] grp);
    booth_digit_e d;
    case (grp)
      3'b000, 3'b111: d = BOOTH_ZERO;
      3'b001, 3'b010: d = BOOTH_P1;
      3'b011:         d = BOOTH_P2;
      3'b100:         d = BOOTH_M2;
      3'b101, 3'b110: d = BOOTH_M1;
      default:        d = BOOTH_ZERO;
    endcase
    return d;
  endfunction

  function automatic int npp(input int width);
    return (width + 2) / 2;
  endfunction

  // Rows left after one 3:2 level: each full triple becomes two rows, leftovers pass through.
  function automatic int csa_rows(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  function automatic int rows_after(input int n, input int levels);
    int r;
    r = n;
    for (int l = 0; l < levels; l++) r = csa_rows(r);
    return r;
  endfunction

  function automatic int csa_levels(input int n);
    int r;
    int l;
    r = n;
    l = 0;
    while (r > 2) begin
      r = csa_rows(r);
      l++;
    end
    return l;
  endfunction

  // Tree level captured by register stage k; the last stage always takes the final sum/carry.
  function automatic int cut_level(input int k, input int levels, input int stages);
    return ((k + 1) * levels) / stages;
  endfunction

  function automatic int cut_stage(input int level, input int levels, input int stages);
    int s;
    s = -1;
    for (int k = 0; k < stages - 1; k++) begin
      if (cut_level(k, levels, stages) == level) s = k;
    end
    return s;
  endfunction

endpackage

// File: rtl/mul_booth_pp.sv
// One radix-4 Booth partial product: a 3-bit multiplier window selects 0, +-y or +-2y,
// sign-extended to the full product width and placed at weight 4^IDX.
module mul_booth_pp
  import mul_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IDX    = 0
) (
  input  logic [2:0]          digit,
  input  logic [DATA_W+1:0]   y_ext,
  output logic [2*DATA_W-1:0] pp
);
  localparam int EW = DATA_W + 2;
  localparam int PW = 2 * DATA_W;
  localparam int SH = 2 * IDX;

  booth_digit_e  code_s;
  logic [PW-1:0] y_sx_s;
  logic [PW-1:0] mag_s;

  assign code_s = booth_encode(digit);
  assign y_sx_s = {{(PW-EW){y_ext[EW-1]}}, y_ext};

  // Digit-selected multiple of y; negation wraps modulo 2^PW.
  always_comb begin
    mag_s = '0;
    case (code_s)
      BOOTH_ZERO: mag_s = '0;
      BOOTH_P1:   mag_s = y_sx_s;
      BOOTH_P2:   mag_s = y_sx_s << 1;
      BOOTH_M1:   mag_s = -y_sx_s;
      BOOTH_M2:   mag_s = -(y_sx_s << 1);
      default:    mag_s = '0;
    endcase
  end

  assign pp = mag_s << SH;

endmodule

// File: rtl/booth_wallace_mul_pipe.sv
// Pipelined radix-4 Booth / Wallace-tree multiplier with valid/ready handshake,
// per-operation tag, signed/unsigned mode and flush.
module booth_wallace_mul_pipe
  import mul_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 5
) (
  input  logic                mul_clk,
  input  logic                resetn,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                mul_signed,
  input  logic [DATA_W-1:0]   x,
  input  logic [DATA_W-1:0]   y,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] result,
  output logic [TAG_W-1:0]    out_tag
);
  localparam int EW  = DATA_W + 2;
  localparam int PW  = 2 * DATA_W;
  localparam int NPP = npp(DATA_W);
  localparam int LV  = csa_levels(NPP);
  localparam int LS  = PIPE_STAGES - 1;

  logic [EW-1:0]    x_ext_s;
  logic [EW-1:0]    y_ext_s;
  logic [EW:0]      x_dig_s;
  logic [PW-1:0]    lvl_s     [0:LV][0:NPP-1];
  logic [PW-1:0]    lin_s     [1:LV][0:NPP-1];
  logic [PW-1:0]    stage_d_s [0:LS][0:NPP-1];
  logic [PW-1:0]    stage_r   [0:LS][0:NPP-1];
  logic [TAG_W-1:0] tag_in_s  [0:LS];
  logic [TAG_W-1:0] tag_r     [0:LS];
  logic [LS:0]      v_r;
  logic [LS:0]      v_in_s;
  logic [PIPE_STAGES:0] en_s;
  logic             accept_s;

  // Two extra bits make the unsigned case a non-negative two's-complement value.
  assign x_ext_s = mul_signed ? {{2{x[DATA_W-1]}}, x} : {2'b00, x};
  assign y_ext_s = mul_signed ? {{2{y[DATA_W-1]}}, y} : {2'b00, y};
  assign x_dig_s = {x_ext_s, 1'b0};

  for (genvar i = 0; i < NPP; i++) begin : g_pp
    mul_booth_pp #(
      .DATA_W (DATA_W),
      .IDX    (i)
    ) u_pp (
      .digit  (x_dig_s[2*i+2:2*i]),
      .y_ext  (y_ext_s),
      .pp     (lvl_s[0][i])
    );
  end

  // Level l reduces the rows of level l-1, taken from a stage register when a cut sits there.
  for (genvar l = 1; l <= LV; l++) begin : g_lvl
    localparam int RI = rows_after(NPP, l - 1);
    localparam int G  = RI / 3;
    localparam int CI = cut_stage(l - 1, LV, PIPE_STAGES);
    for (genvar j = 0; j < NPP; j++) begin : g_in
      if (CI >= 0) begin : g_reg
        assign lin_s[l][j] = stage_r[CI][j];
      end else begin : g_comb
        assign lin_s[l][j] = lvl_s[l-1][j];
      end
    end
    for (genvar j = 0; j < NPP; j++) begin : g_row
      if (j < 2 * G) begin : g_csa
        if (j % 2 == 0) begin : g_sum
          assign lvl_s[l][j] = lin_s[l][3*(j/2)] ^ lin_s[l][3*(j/2)+1] ^ lin_s[l][3*(j/2)+2];
        end else begin : g_carry
          assign lvl_s[l][j] = ((lin_s[l][3*(j/2)]   & lin_s[l][3*(j/2)+1]) |
                                (lin_s[l][3*(j/2)]   & lin_s[l][3*(j/2)+2]) |
                                (lin_s[l][3*(j/2)+1] & lin_s[l][3*(j/2)+2])) << 1;
        end
      end else if (j < 2 * G + RI % 3) begin : g_pass
        assign lvl_s[l][j] = lin_s[l][3*G + (j - 2*G)];
      end else begin : g_empty
        assign lvl_s[l][j] = '0;
      end
    end
  end

  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_cut
    localparam int CL = cut_level(k, LV, PIPE_STAGES);
    for (genvar j = 0; j < NPP; j++) begin : g_row
      assign stage_d_s[k][j] = lvl_s[CL][j];
    end
  end

  // Advance chain: a stage may load when it is empty or its occupant moves on.
  always_comb begin
    en_s   = '0;
    v_in_s = '0;
    for (int k = 0; k < PIPE_STAGES; k++) tag_in_s[k] = '0;
    en_s[PIPE_STAGES] = out_ready;
    for (int k = PIPE_STAGES - 1; k >= 0; k--) en_s[k] = ~v_r[k] | en_s[k+1];
    in_ready    = en_s[0];
    accept_s    = in_valid & en_s[0] & ~flush;
    v_in_s[0]   = accept_s;
    tag_in_s[0] = in_tag;
    for (int k = 1; k < PIPE_STAGES; k++) begin
      v_in_s[k]   = v_r[k-1];
      tag_in_s[k] = tag_r[k-1];
    end
  end

  // Stage registers; flush only drops validity, reset clears everything.
  always_ff @(posedge mul_clk) begin
    if (!resetn) begin
      v_r <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) begin
        tag_r[k] <= '0;
        for (int j = 0; j < NPP; j++) stage_r[k][j] <= '0;
      end
    end else begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        if (flush) begin
          v_r[k] <= 1'b0;
        end else if (en_s[k]) begin
          v_r[k] <= v_in_s[k];
        end
        if (en_s[k] && v_in_s[k]) begin
          tag_r[k] <= tag_in_s[k];
          for (int j = 0; j < NPP; j++) stage_r[k][j] <= stage_d_s[k][j];
        end
      end
    end
  end

  assign out_valid = v_r[LS];
  assign out_tag   = tag_r[LS];
  assign result    = stage_r[LS][0] + stage_r[LS][1];

endmodule

// File: tb/tb_booth_wallace_mul_pipe.sv
// Self-checking bench: directed corner products, handshake stalls, flush and reset,
// then random traffic scored against an arithmetic reference queue.
module tb_booth_wallace_mul_pipe;
  localparam int DW = 32;
  localparam int PS = 2;
  localparam int TW = 5;
  localparam int PW = 2 * DW;

  logic          mul_clk = 1'b0;
  logic          resetn, flush, in_valid, in_ready, mul_signed, out_valid, out_ready;
  logic [DW-1:0] x, y;
  logic [TW-1:0] in_tag, out_tag;
  logic [PW-1:0] result;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [PW-1:0] prod;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ov_count = 0;
  int first_ov = -1;
  int last_ov = -1;
  int acc_count = 0;

  always #5 mul_clk = ~mul_clk;

  booth_wallace_mul_pipe #(
    .DATA_W      (DW),
    .PIPE_STAGES (PS),
    .TAG_W       (TW)
  ) dut (
    .mul_clk    (mul_clk),
    .resetn     (resetn),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mul_signed (mul_signed),
    .x          (x),
    .y          (y),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .out_tag    (out_tag)
  );

  function automatic logic [PW-1:0] ref_mul(input logic sgn, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [PW-1:0] ea, eb;
    ea = sgn ? {{DW{a[DW-1]}}, a} : {{DW{1'b0}}, a};
    eb = sgn ? {{DW{b[DW-1]}}, b} : {{DW{1'b0}}, b};
    return ea * eb;
  endfunction

  function automatic logic [DW-1:0] pick();
    logic [DW-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = DW'(1);
      2:       v = '1;
      3:       v = {1'b1, {(DW-1){1'b0}}};
      4:       v = {1'b0, {(DW-1){1'b1}}};
      default: v = DW'($urandom);
    endcase
    return v;
  endfunction

  task automatic check(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Observe one cycle just before the edge, update the scoreboard, then advance.
  task automatic tick();
    exp_t e;
    #1;
    if (out_valid === 1'b1) begin
      ov_count++;
      if (first_ov < 0) first_ov = cyc;
      last_ov = cyc;
      checks++;
      assert (sb.size() != 0)
      else begin
        errors++;
        $error("FAIL spurious_output: observed out_valid=1 tag=%0d expected=no pending op", out_tag);
      end
      if (sb.size() != 0) begin
        check("sb_result", result, sb[0].prod);
        check("sb_tag", PW'(out_tag), PW'(sb[0].tag));
        if (out_ready) void'(sb.pop_front());
      end
    end
    if (!resetn || flush) begin
      sb.delete();
    end else if (in_valid && in_ready) begin
      e.tag  = in_tag;
      e.prod = ref_mul(mul_signed, x, y);
      sb.push_back(e);
      acc_count++;
    end
    @(posedge mul_clk);
    @(negedge mul_clk);
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_empty", PW'(sb.size()), '0);
    check("drain_idle", PW'(out_valid), '0);
  endtask

  task automatic single(input string name, input logic sgn, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [TW-1:0] t, input logic [PW-1:0] want);
    int lat;
    mul_signed = sgn;
    x          = a;
    y          = b;
    in_tag     = t;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    flush      = 1'b0;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check({name, "_latency"}, PW'(lat), PW'(PS));
    check({name, "_result"}, result, want);
    check({name, "_tag"}, PW'(out_tag), PW'(t));
    drain(20);
  endtask

  task automatic offer(input logic [TW-1:0] t);
    mul_signed = 1'($urandom_range(0, 1));
    x          = pick();
    y          = pick();
    in_tag     = t;
    in_valid   = 1'b1;
    tick();
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; mul_signed = 1'b0;
    x = '0; y = '0; in_tag = '0; out_ready = 1'b0;
    repeat (3) @(posedge mul_clk);
    @(negedge mul_clk);
    #1;
    check("rst_out_valid", PW'(out_valid), '0);
    check("rst_result", result, '0);
    check("rst_out_tag", PW'(out_tag), '0);
    check("rst_in_ready", PW'(in_ready), PW'(1));
    resetn = 1'b1;

    single("min_sq", 1'b1, 32'h8000_0000, 32'h8000_0000, 5'd1, 64'h4000_0000_0000_0000);
    single("umax_sq", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 64'hFFFF_FFFE_0000_0001);
    single("smax_sq", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 64'h0000_0000_0000_0001);

    // Eight back-to-back operations with a free-running consumer.
    ov_count = 0; first_ov = -1; last_ov = -1; acc_count = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) offer(TW'(i));
    drain(20);
    check("b2b_accepts", PW'(acc_count), PW'(8));
    check("b2b_valid_cycles", PW'(ov_count), PW'(8));
    check("b2b_consecutive", PW'(last_ov - first_ov), PW'(7));

    // Fill with the consumer blocked, hold, then release.
    acc_count = 0;
    out_ready = 1'b0;
    for (int i = 0; i < PS + 3; i++) offer(TW'(8 + i));
    #1;
    check("full_in_ready", PW'(in_ready), '0);
    check("full_accepts", PW'(acc_count), PW'(PS));
    check("full_out_valid", PW'(out_valid), PW'(1));
    in_valid = 1'b0;
    repeat (4) tick();
    drain(20);

    // Flush with two operations in flight and a new one offered.
    out_ready = 1'b1;
    offer(5'd20);
    offer(5'd21);
    flush = 1'b1;
    offer(5'd31);
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", PW'(out_valid), '0);
    repeat (PS + 2) tick();
    drain(5);

    // Reset in the middle of a stream.
    offer(5'd22);
    offer(5'd23);
    resetn = 1'b0;
    offer(5'd24);
    check("midrst_out_valid", PW'(out_valid), '0);
    check("midrst_result", result, '0);
    check("midrst_out_tag", PW'(out_tag), '0);
    check("midrst_in_ready", PW'(in_ready), PW'(1));
    resetn = 1'b1;
    in_valid = 1'b0;
    repeat (PS + 2) tick();
    drain(5);

    // Random traffic with consumer throttling and rare flushes.
    for (int i = 0; i < 3000; i++) begin
      in_valid   = ($urandom_range(0, 99) < 70);
      out_ready  = ($urandom_range(0, 99) < 60);
      flush      = ($urandom_range(0, 199) == 0);
      mul_signed = 1'($urandom_range(0, 1));
      x          = pick();
      y          = pick();
      in_tag     = TW'($urandom);
      tick();
    end
    drain(50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
